s2_conv_sequencer: RTL
======================

S2_CONV_SEQUENCER -- requirements
Module: s2_conv_sequencer

Interface
REQ-001 Parameter DW, default 17: width of the datapath result and of out_data.
REQ-002 Parameter LAT, default 2: fixed datapath latency in cycles, from issue to result valid; allowed range 1..7.
REQ-003 Parameter DEPTH, default 4: result buffer depth; SHALL be at least LAT+1.
REQ-004 Parameter POS_LAST, default 3: last window row/column index; allowed range 0..3.
REQ-005 Parameter CH_LAST, default 0: last channel-group index driven on proc_dir; allowed range 0..3.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port start, input, 1 bit: a pulse that requests one full frame pass.
REQ-009 Port busy, output, 1 bit: high in every state except IDLE.
REQ-010 Port done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-011 Port proc_dir, output, 2 bits: channel-group select to the datapath.
REQ-012 Port proc_counter, output, 4 bits: window row in [3:2] and window column in [1:0].
REQ-013 Port issue_valid, output, 1 bit: high when proc_dir/proc_counter hold a window being issued this cycle.
REQ-014 Port res_data, input, DW bits: datapath result, valid exactly LAT cycles after its issue cycle.
REQ-015 Port out_valid, output, 1 bit; Port out_ready, input, 1 bit: valid/ready handshake on the result stream.
REQ-016 Port out_data, output, DW bits: buffered result.
REQ-017 Port out_addr, output, 6 bits: {proc_dir, row, col} of the window that produced out_data.
REQ-018 Port out_last, output, 1 bit: high together with out_valid on the final result of the frame.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN when start=1; start SHALL be ignored in every other state.
REQ-021 Issue order: proc_dir is the outer loop, row the middle loop, col the inner loop; all three start at 0, each runs 0..its LAST value.
REQ-022 Issue condition: state is RUN and inflight + buffer_count < DEPTH; issue_valid SHALL equal this condition.
REQ-023 Counters SHALL advance only in a cycle where an issue occurs; otherwise they hold their values.
REQ-024 The first issue SHALL occur in the cycle after start is sampled.
REQ-025 RUN->DRAIN on the issue of the last window (CH_LAST, POS_LAST, POS_LAST).
REQ-026 A LAT-deep valid/address shift register SHALL track in-flight windows; inflight is the number of set valid bits in it.
REQ-027 When the shift-register output is valid, {res_data, address} SHALL be written into the FIFO, and out_valid SHALL be visible the next cycle.
REQ-028 A FIFO pop occurs on out_valid && out_ready; a simultaneous push and pop SHALL leave buffer_count unchanged.
REQ-029 The FIFO SHALL never overflow, because of the credit rule in REQ-022; a push while full is a design error and SHALL be flagged by an assertion.
REQ-030 out_data and out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 DRAIN->DONE when inflight=0 and the buffer is empty; DONE lasts one cycle with done=1, then the FSM returns to IDLE.
REQ-032 Throughput: with out_ready held at 1 there SHALL be one issue per cycle, giving (CH_LAST+1)*(POS_LAST+1)^2 consecutive issue cycles.
REQ-033 out_addr wrap: col wraps to 0 with row+1; row wraps to 0 with proc_dir+1.

Reset
REQ-034 On rst_n=0, at any time including mid-frame: state SHALL go to IDLE, counters, inflight and buffer SHALL clear, and all outputs SHALL go to 0.
REQ-035 After reset is released, no result from the aborted frame SHALL appear on the output stream.

Verification
REQ-036 Defaults, out_ready=1, start pulsed at cycle 0 -> issue_valid high in cycles 1..16, proc_counter runs 0..15, first out_valid in cycle 4, out_addr runs 0..15, out_last with addr 15, done in cycle 20.
REQ-037 out_ready=0 throughout the frame -> exactly 4 issues, then issue_valid stays 0 and the FIFO holds 4 entries; releasing out_ready resumes issue in order with no loss and no duplicates.
REQ-038 out_ready toggling 1,0,1,0 -> every address 0..15 delivered exactly once, in order, with data stable across every stall.
REQ-039 CH_LAST=1, POS_LAST=1 -> 8 issues in address order 0,1,4,5,16,17,20,21.
REQ-040 start re-pulsed during RUN -> ignored and the frame completes normally; rst_n pulsed low at issue 7 -> all outputs 0 and busy=0, and the next start runs a clean 16-window frame.

Source files
------------

// File: rtl/s2_conv_sequencer.sv
// s2_conv_sequencer: drives window addresses to a fixed-latency convolution datapath.
// Results are collected into a small buffer and streamed out with a valid/ready handshake.
// A credit rule only issues a window when the buffer is sure to have room for its result,
// so the buffer can never overflow, whatever out_ready does.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              pulse requesting one frame pass (ignored unless idle)
//   busy, done         high outside IDLE / one-cycle end-of-frame pulse
//   proc_dir           channel-group select to the datapath
//   proc_counter       {row, col} of the window being issued
//   issue_valid        a window is issued this cycle
//   res_data           datapath result, valid LAT cycles after its issue
//   out_valid/ready    result stream handshake
//   out_data/addr      buffered result and its {proc_dir, row, col}
//   out_last           final result of the frame
module s2_conv_sequencer #(
    parameter int unsigned DW       = 17,
    parameter int unsigned LAT      = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned POS_LAST = 3,
    parameter int unsigned CH_LAST  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    proc_dir,
    output logic [3:0]    proc_counter,
    output logic          issue_valid,
    input  logic [DW-1:0] res_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_addr,
    output logic          out_last
);

    // Wide enough for inflight + buffer occupancy.
    localparam int unsigned CW = $clog2(DEPTH + LAT + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] PosLast = 2'(POS_LAST);
    localparam logic [1:0] ChLast  = 2'(CH_LAST);
    localparam logic [5:0] LastAddr = {ChLast, PosLast, PosLast};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0] dir_q, row_q, col_q;
    logic       last_window;

    logic [LAT-1:0] sr_valid_q;
    logic [5:0]     sr_addr_q [LAT];
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  inflight_next;

    logic [DW+5:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           push, pop;
    logic [DW+5:0]  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------------------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_window = (dir_q == ChLast) && (row_q == PosLast) && (col_q == PosLast);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (issue_valid && last_window) state_d = StDrain;
            // Look at post-edge occupancy so DONE follows the final pop directly.
            StDrain: if (inflight_next == '0 && count_d == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        issue_valid = (state_q == StRun) && ((inflight + count_q) < CW'(DEPTH));
    end

    // ---------------------------------------------------------------------------------------
    // Window counters: dir outer, row middle, col inner
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 2'd0;
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else if (issue_valid) begin
            if (col_q == PosLast) begin
                col_q <= 2'd0;
                if (row_q == PosLast) begin
                    row_q <= 2'd0;
                    dir_q <= (dir_q == ChLast) ? 2'd0 : dir_q + 2'd1;
                end else begin
                    row_q <= row_q + 2'd1;
                end
            end else begin
                col_q <= col_q + 2'd1;
            end
        end
    end

    assign proc_dir     = dir_q;
    assign proc_counter = {row_q, col_q};

    // ---------------------------------------------------------------------------------------
    // In-flight tracker, aligned with the datapath latency
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                sr_addr_q[i] <= 6'd0;
            end
        end else begin
            sr_valid_q[0] <= issue_valid;
            sr_addr_q[0]  <= {dir_q, row_q, col_q};
            for (int i = 1; i < int'(LAT); i++) begin
                sr_valid_q[i] <= sr_valid_q[i-1];
                sr_addr_q[i]  <= sr_addr_q[i-1];
            end
        end
    end

    always_comb begin
        inflight      = '0;
        inflight_next = CW'(issue_valid);
        for (int i = 0; i < int'(LAT); i++) begin
            inflight = inflight + CW'(sr_valid_q[i]);
            // The last stage leaves the tracker (into the buffer) at this edge.
            if (i < int'(LAT) - 1) begin
                inflight_next = inflight_next + CW'(sr_valid_q[i]);
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Result buffer
    // ---------------------------------------------------------------------------------------
    assign push    = sr_valid_q[LAT-1];
    assign pop     = out_valid && out_ready;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_data, sr_addr_q[LAT-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    // Storage is not reset, so gate the outputs to keep them at 0 while empty.
    assign out_data  = out_valid ? head[DW+5:6] : '0;
    assign out_addr  = out_valid ? head[5:0] : 6'd0;
    assign out_last  = out_valid && (head[5:0] == LastAddr);

    buffer_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == CW'(DEPTH))))
        else $error("result buffer push while full");

endmodule
